// File: rtl/sonar_audio_pkg.sv
// Shared widths and constants for the sonar audio FIR -> PWM output chain.
// No logic; constants only.
// Consumed by fir_duty_adapter, its interface and the PWM stage.
package sonar_audio_pkg;

    // Signed FIR output sample width
    localparam int FIR_OUT_W = 30;

    // Unsigned duty byte width and its midscale (zero signal) value
    localparam int DUTY_W = 8;
    localparam logic [DUTY_W-1:0] DUTY_MID = 8'h80;

    // Width of the saturating bring-up event counters
    localparam int EVT_CNT_W = 16;

endpackage

// File: rtl/fir_duty_adapter_if.sv
// Signal bundle between the FIR sample source / PWM sink and fir_duty_adapter.
// No latency; wires only.
// No backpressure: samples are accepted on every in_valid cycle.
interface fir_duty_adapter_if
    import sonar_audio_pkg::*;
#(
    parameter int IN_W  = FIR_OUT_W,
    parameter int OUT_W = DUTY_W,
    parameter int CNT_W = EVT_CNT_W
);
    logic signed [IN_W-1:0]  in_data;
    logic                    in_valid;
    logic [4:0]              shift;
    logic                    period_start;
    logic                    clear;
    logic [OUT_W-1:0]        duty;
    logic                    pending_valid;
    logic [CNT_W-1:0]        clip_cnt;
    logic [CNT_W-1:0]        overrun_cnt;

    // Sample source / PWM side: drives samples and timing, observes duty
    modport master (
        output in_data, in_valid, shift, period_start, clear,
        input  duty, pending_valid, clip_cnt, overrun_cnt
    );

    // Adapter side
    modport slave (
        input  in_data, in_valid, shift, period_start, clear,
        output duty, pending_valid, clip_cnt, overrun_cnt
    );
endinterface

// File: rtl/fir_duty_adapter_round_sat.sv
// Shift/round and clamp helpers for a signed tap: two independent combinational sections.
// Zero latency; the caller decides where to put a register between the sections.
// No flow control; pure function of the inputs.
module round_sat #(
    parameter int IN_W  = 30,
    parameter int OUT_W = 8
) (
    // rounding section
    input  logic signed [IN_W-1:0] i_data,
    input  logic [4:0]             i_shift,
    output logic signed [IN_W:0]   o_rnd,
    // clamp section
    input  logic signed [IN_W:0]   i_rnd,
    output logic [OUT_W-1:0]       o_sat,
    output logic                   o_clip
);
    // Shifting further than the sample width only ever yields 0 or -1
    localparam logic [4:0] SH_MAX = 5'(IN_W - 1);

    localparam logic signed [IN_W:0] SAT_MAX = (IN_W+1)'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] SAT_MIN = ~SAT_MAX;
    localparam logic [OUT_W-1:0]     OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]     OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic [4:0]             w_sh;
    logic signed [IN_W:0]   w_bias;
    logic signed [IN_W:0]   w_sum;

    // Round half up: add half an output LSB, then arithmetic shift (one guard bit)
    always_comb begin
        w_sh   = (i_shift > SH_MAX) ? SH_MAX : i_shift;
        w_bias = '0;
        if (w_sh != 5'd0) begin
            w_bias[w_sh - 5'd1] = 1'b1;
        end
        w_sum = {i_data[IN_W-1], i_data} + w_bias;
        o_rnd = w_sum >>> w_sh;
    end

    // Clamp into the signed output range and flag any clamp
    always_comb begin
        o_clip = 1'b0;
        o_sat  = i_rnd[OUT_W-1:0];
        if (i_rnd > SAT_MAX) begin
            o_sat  = OUT_MAX;
            o_clip = 1'b1;
        end else if (i_rnd < SAT_MIN) begin
            o_sat  = OUT_MIN;
            o_clip = 1'b1;
        end
    end
endmodule

// File: rtl/fir_duty_adapter.sv
// Converts signed FIR samples to offset-binary PWM duty, applied only at PWM period starts.
// Latency: in_valid at edge N -> duty at edge N+2 earliest (period_start high in cycle N+1).
// No backpressure: one sample per clock accepted; an unconsumed pending sample is overwritten (counted).
module fir_duty_adapter
    import sonar_audio_pkg::*;
#(
    parameter int IN_W  = FIR_OUT_W,
    parameter int OUT_W = DUTY_W,
    parameter int CNT_W = EVT_CNT_W
) (
    input  logic              clk,
    input  logic              reset_n,
    fir_duty_adapter_if.slave bus
);
    localparam logic [OUT_W-1:0] MID = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0]  r_s1;
    logic                  r_s1_vld;
    logic [OUT_W-1:0]      r_duty;
    logic [OUT_W-1:0]      r_pend;
    logic                  r_pend_vld;
    logic [CNT_W-1:0]      r_clip_cnt;
    logic [CNT_W-1:0]      r_ovr_cnt;

    logic signed [IN_W:0]  w_rnd;
    logic [OUT_W-1:0]      w_sat;
    logic                  w_clip;
    logic [OUT_W-1:0]      w_res;
    logic                  w_clip_inc;
    logic                  w_ovr_inc;

    round_sat #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .i_data  (bus.in_data),
        .i_shift (bus.shift),
        .o_rnd   (w_rnd),
        .i_rnd   (r_s1),
        .o_sat   (w_sat),
        .o_clip  (w_clip)
    );

    // Two's complement to offset binary: flip the sign bit
    assign w_res      = {~w_sat[OUT_W-1], w_sat[OUT_W-2:0]};
    assign w_clip_inc = r_s1_vld & w_clip;
    // A new sample arriving while one is still pending always discards the older one
    assign w_ovr_inc  = r_s1_vld & r_pend_vld;

    // Stage 1: register the shifted/rounded sample
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1     <= '0;
            r_s1_vld <= 1'b0;
        end else begin
            r_s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1 <= w_rnd;
            end
        end
    end

    // Duty/pending buffer: duty only moves on period_start, latest sample wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_duty     <= MID;
            r_pend     <= MID;
            r_pend_vld <= 1'b0;
        end else if (r_s1_vld) begin
            if (bus.period_start) begin
                r_duty     <= w_res;
                r_pend_vld <= 1'b0;
            end else begin
                r_pend     <= w_res;
                r_pend_vld <= 1'b1;
            end
        end else if (bus.period_start && r_pend_vld) begin
            r_duty     <= r_pend;
            r_pend_vld <= 1'b0;
        end
    end

    // Saturating event counters; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_clip_cnt <= '0;
            r_ovr_cnt  <= '0;
        end else if (bus.clear) begin
            r_clip_cnt <= '0;
            r_ovr_cnt  <= '0;
        end else begin
            if (w_clip_inc && (r_clip_cnt != '1)) begin
                r_clip_cnt <= r_clip_cnt + CNT_W'(1);
            end
            if (w_ovr_inc && (r_ovr_cnt != '1)) begin
                r_ovr_cnt <= r_ovr_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.duty          = r_duty;
    assign bus.pending_valid = r_pend_vld;
    assign bus.clip_cnt      = r_clip_cnt;
    assign bus.overrun_cnt   = r_ovr_cnt;
endmodule

// File: tb/tb_fir_duty_adapter.sv
// Directed self-checking bench for fir_duty_adapter.
// Inputs driven 1ns after the rising edge, outputs sampled at the same point.
// Expected values are hand-computed constants.
module tb_fir_duty_adapter;
    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    fir_duty_adapter_if #(.IN_W(30), .OUT_W(8), .CNT_W(16)) bus ();

    fir_duty_adapter #(.IN_W(30), .OUT_W(8), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // One in_valid cycle; returns 1ns after the capturing edge (s1 valid now)
    task automatic send(input logic [29:0] d, input logic [4:0] sh);
        bus.in_data  = d;
        bus.shift    = sh;
        bus.in_valid = 1'b1;
        idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse();
        bus.period_start = 1'b1;
        idle();
        bus.period_start = 1'b0;
    endtask

    // Sample then period_start in the very next cycle: duty at N+2
    task automatic send_apply(input logic [29:0] d, input logic [4:0] sh);
        send(d, sh);
        pulse();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset_n          = 1'b0;
        bus.in_data      = '0;
        bus.in_valid     = 1'b0;
        bus.shift        = '0;
        bus.period_start = 1'b0;
        bus.clear        = 1'b0;
        idle();
        idle();
        check("rst_duty", bus.duty, 8'h80);
        check("rst_pend", bus.pending_valid, 1'b0);
        check("rst_clip", bus.clip_cnt, 16'h0000);
        check("rst_ovr",  bus.overrun_cnt, 16'h0000);
        reset_n = 1'b1;
        idle();

        // Scaling, with latency: duty unchanged at N+1, updated at N+2
        send(30'h0040_0000, 5'd22);
        check("lat_n1_duty", bus.duty, 8'h80);
        pulse();
        check("scale_duty", bus.duty, 8'h81);
        check("scale_clip", bus.clip_cnt, 16'h0000);
        check("scale_pend", bus.pending_valid, 1'b0);

        // Rounding (half up)
        send_apply(30'h3FE0_0000, 5'd22);
        check("rnd_neg_half", bus.duty, 8'h80);
        send_apply(30'h0020_0000, 5'd22);
        check("rnd_pos_half", bus.duty, 8'h81);
        send_apply(30'h3FDF_FFFF, 5'd22);
        check("rnd_neg_half_m1", bus.duty, 8'h7F);

        // period_start with nothing pending: no change
        pulse();
        check("ps_idle_duty", bus.duty, 8'h7F);

        // Saturation
        send_apply(30'h1FFF_FFFF, 5'd22);
        check("sat_hi_duty", bus.duty, 8'hFF);
        check("sat_hi_clip", bus.clip_cnt, 16'h0001);
        send_apply(30'h2000_0000, 5'd22);
        check("sat_lo_duty", bus.duty, 8'h00);
        check("sat_lo_clip", bus.clip_cnt, 16'h0001);
        send_apply(30'h2000_0000, 5'd31);
        check("shift_cap_duty", bus.duty, 8'h7F);
        check("shift_cap_clip", bus.clip_cnt, 16'h0001);

        // Buffering and overrun
        send(30'h0040_0000, 5'd22);
        send(30'h00C0_0000, 5'd22);
        idle();
        check("buf_pend", bus.pending_valid, 1'b1);
        check("buf_ovr",  bus.overrun_cnt, 16'h0001);
        check("buf_duty_hold", bus.duty, 8'h7F);
        pulse();
        check("buf_apply_duty", bus.duty, 8'h83);
        check("buf_apply_pend", bus.pending_valid, 1'b0);

        // New sample and period_start together while one is pending
        send(30'h0040_0000, 5'd22);
        idle();
        check("same_pend_pre", bus.pending_valid, 1'b1);
        send_apply(30'h0140_0000, 5'd22);
        check("same_duty", bus.duty, 8'h85);
        check("same_ovr",  bus.overrun_cnt, 16'h0002);
        check("same_pend", bus.pending_valid, 1'b0);

        // clear in the same cycle as a clip (and an overrun-free cycle)
        send(30'h1FFF_FFFF, 5'd22);
        bus.clear = 1'b1;
        idle();
        bus.clear = 1'b0;
        check("clr_clip", bus.clip_cnt, 16'h0000);
        check("clr_ovr",  bus.overrun_cnt, 16'h0000);
        check("clr_duty_hold", bus.duty, 8'h85);

        // Counter saturation: 70000 back-to-back clipping samples
        bus.in_data  = 30'h1FFF_FFFF;
        bus.shift    = 5'd22;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            @(posedge clk);
        end
        #1;
        check("sat_clip_cnt", bus.clip_cnt, 16'hFFFF);
        check("sat_ovr_cnt",  bus.overrun_cnt, 16'hFFFF);
        check("sat_pend",     bus.pending_valid, 1'b1);

        // Asynchronous reset mid-stream
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_duty", bus.duty, 8'h80);
        check("arst_pend", bus.pending_valid, 1'b0);
        check("arst_clip", bus.clip_cnt, 16'h0000);
        check("arst_ovr",  bus.overrun_cnt, 16'h0000);
        bus.in_valid = 1'b0;
        idle();
        reset_n = 1'b1;
        idle();
        send_apply(30'h0040_0000, 5'd22);
        check("post_rst_duty", bus.duty, 8'h81);
        check("post_rst_clip", bus.clip_cnt, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_duty_adapter.md
Name: fir_duty_adapter

Overview:
- Downstream stage of the decimating FIR: consumes the FIR's signed sample stream and produces the unsigned duty byte for the PWM output stage.
- Performs programmable arithmetic right shift with rounding, then saturation to OUT_W bits, then conversion from two's complement to offset binary.
- Buffers the result so duty changes only at a PWM period boundary. Counts clip and overrun events for bring-up.

Parameters:
- IN_W, 30, width of signed FIR output sample.
- OUT_W, 8, width of unsigned duty output.
- CNT_W, 16, width of saturating event counters.

Ports:
- clk  in  1  system clock (same domain as FIR output)
- reset_n  in  1  asynchronous active-low reset
- in_data  in  IN_W  signed FIR sample
- in_valid  in  1  in_data valid this cycle
- shift  in  5  right-shift amount, sampled with in_valid
- period_start  in  1  one-cycle pulse at PWM counter wrap
- clear  in  1  synchronous clear of both counters
- duty  out  OUT_W  offset-binary duty to PWM
- pending_valid  out  1  a converted sample awaits period_start
- clip_cnt  out  CNT_W  saturating count of clipped samples
- overrun_cnt  out  CNT_W  saturating count of discarded samples

Behaviour:
- Reset values: duty = 2^(OUT_W-1) (8'h80, midscale); pending_valid = 0; clip_cnt = 0; overrun_cnt = 0; all pipeline valids = 0.
- Stage 1, registered on an in_valid cycle:
  - Effective shift is min(shift, IN_W-1).
  - s1 = (in_data + (sh>0 ? 2^(sh-1) : 0)) >>> sh, computed in IN_W+1 bits so the rounding add cannot overflow.
  - Rounding is round-half-up.
  - s1_valid <= in_valid.
- Stage 2, combinational from s1 while s1_valid = 1:
  - Clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. A clamp asserts clip.
  - Invert the MSB to get offset binary, giving result r.
- Output update at each clock edge where s1_valid = 1:
  - If period_start = 1: duty <= r. If pending_valid was 1, the old pending sample is discarded, overrun_cnt increments, and pending_valid <= 0 (latest wins).
  - If period_start = 0: pending <= r and pending_valid <= 1. If pending_valid was already 1, overrun_cnt increments.
- Output update at each clock edge where s1_valid = 0:
  - If period_start = 1 and pending_valid = 1: duty <= pending and pending_valid <= 0.
  - Otherwise duty holds.
- clip_cnt increments once per s1_valid cycle in which the clamp asserts.
- Counters saturate at all-ones and never wrap.
- clear zeroes both counters and wins over a same-cycle increment. It does not touch the data path.
- Latency: in_valid at edge N gives s1 at edge N+1. duty updates at edge N+2 at the earliest, when period_start is high in cycle N+1. Otherwise it updates at the first period_start after that.
- Back-to-back in_valid is fully pipelined (one sample per clock). With in_valid tied high and no period_start, overrun_cnt climbs every cycle; this is expected.
- period_start with nothing pending and no s1_valid: no state change.
- An asynchronous reset_n assertion mid-stream discards in-flight samples and returns every output to its reset value immediately.

Decomposition:
- Shared package sonar_audio_pkg holds FIR_OUT_W = 30, DUTY_W = 8, DUTY_MID = 8'h80 and EVT_CNT_W = 16. TOP and the PWM stage use the same constants.
- One natural sub-module, round_sat: purely combinational shift, round and clamp, plus the clip flag. Parameterised by IN_W and OUT_W, and reusable for other decimated taps.
- The pipeline registers, pending buffer and counters live in fir_duty_adapter.

Test Plan:
- Scaling: shift = 22, in_data = 2^22, then period_start → duty = 8'h81 at N+2; clip_cnt = 0.
- Rounding:
  - in_data = 2^21, shift 22 → 8'h81.
  - in_data = -2^21 → 8'h80.
  - in_data = -(2^21 + 1) → 8'h7F.
- Saturation:
  - in_data = 30'h1FFF_FFFF, shift 22 → duty 8'hFF, clip_cnt = 1.
  - in_data = 30'h2000_0000 (-2^29), shift 22 → duty 8'h00, clip_cnt unchanged.
  - shift = 31 with in_data = 30'h2000_0000 → treated as shift 29, duty 8'h7F.
- Buffering and overrun:
  - Samples 2^22 then 3·2^22 with no period_start → pending_valid = 1, overrun_cnt = 1.
  - Next period_start → duty = 8'h83, pending_valid = 0.
  - Same-cycle period_start with s1_valid while a sample is pending → duty = new value, overrun_cnt +1.
- Counter limits: drive 70000 clipping samples → clip_cnt stops at 16'hFFFF. clear asserted in the same cycle as a clip → clip_cnt reads 0 next cycle.
- Reset mid-operation: pull reset_n low while pending_valid = 1 and s1_valid = 1 → duty = 8'h80, pending_valid = 0, counters 0 asynchronously. The first sample after release behaves as in the scaling test.
